// File: rtl/rv32_decode_exec_unit_pkg.sv
// Shared encodings for the RV32IM decode/execute slice: opcodes, ALU operation
// codes, branch conditions, memory access widths and the EX control bundle.
package rv32_decode_exec_unit_pkg;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13
  } alu_op_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic       alu_src;
    logic [2:0] b_type;
    logic       is_branch;
    logic       jal_jump;
    logic       jalr_jump;
    logic       is_lui;
    logic       is_auipc;
  } ex_ctl_t;

  // SUB only exists in register form; in OP-IMM bit 30 belongs to the immediate
  // except for the shift-right encodings.
  function automatic alu_op_e base_alu_op(input logic [2:0] funct3, input logic alt,
                                          input logic is_reg);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32_decode_exec_unit_if.sv
// Bundle between the pipeline and the decode/execute unit: ID instruction,
// EX operands and control, decode results and the registered EX outputs.
interface rv32_decode_exec_unit_if;
  import rv32_decode_exec_unit_pkg::*;

  logic        stall;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm_ex;
  ex_ctl_t     ctl_ex;

  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  alu_op_e     alu_op;
  logic [2:0]  div_op;
  logic        reg_write;
  logic        alu_src;
  logic        is_branch;
  logic        jal_jump;
  logic        jalr_jump;
  logic        is_load;
  logic        is_store;
  logic        div_start;
  logic        is_div_instruction;
  logic        is_lui;
  logic        is_auipc;
  logic        cpu_halt;
  logic        decoder_illegal;
  logic [2:0]  b_type;
  logic [2:0]  load_type;
  logic [2:0]  store_type;
  logic [2:0]  csr_func;

  logic [31:0] result_q;
  logic [31:0] pc_target_q;
  logic        flush_q;

  modport master (
    output stall, instr, pc, rs1_val, rs2_val, imm_ex, ctl_ex,
    input  rd, rs1, rs2, imm, alu_op, div_op, reg_write, alu_src, is_branch,
           jal_jump, jalr_jump, is_load, is_store, div_start, is_div_instruction,
           is_lui, is_auipc, cpu_halt, decoder_illegal, b_type, load_type,
           store_type, csr_func, result_q, pc_target_q, flush_q
  );

  modport slave (
    input  stall, instr, pc, rs1_val, rs2_val, imm_ex, ctl_ex,
    output rd, rs1, rs2, imm, alu_op, div_op, reg_write, alu_src, is_branch,
           jal_jump, jalr_jump, is_load, is_store, div_start, is_div_instruction,
           is_lui, is_auipc, cpu_halt, decoder_illegal, b_type, load_type,
           store_type, csr_func, result_q, pc_target_q, flush_q
  );

endinterface

// File: rtl/rv32_alu_core.sv
// Combinational RV32IM integer ALU, including the four multiply variants.
module rv32_alu_core
  import rv32_decode_exec_unit_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] y
);

  logic signed [32:0] a_ext;
  logic signed [32:0] b_ext;
  logic signed [65:0] prod;
  logic [1:0]         unused_prod_top;

  // One 33x33 signed multiplier serves all variants; the extension bit picks
  // signed or unsigned interpretation of each operand.
  always_comb begin
    a_ext = {((op == ALU_MULH) || (op == ALU_MULHSU)) & a[31], a};
    b_ext = {(op == ALU_MULH) & b[31], b};
    prod  = a_ext * b_ext;
  end

  assign unused_prod_top = prod[65:64];

  always_comb begin
    y = 32'h0;
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_SLL:    y = a << b[4:0];
      ALU_SLT:    y = {31'h0, $signed(a) < $signed(b)};
      ALU_SLTU:   y = {31'h0, a < b};
      ALU_XOR:    y = a ^ b;
      ALU_SRL:    y = a >> b[4:0];
      ALU_SRA:    y = $signed(a) >>> b[4:0];
      ALU_OR:     y = a | b;
      ALU_AND:    y = a & b;
      ALU_MUL:    y = prod[31:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  y = prod[63:32];
      default:    y = 32'h0;
    endcase
  end

endmodule

// File: rtl/rv32_decode_exec_unit.sv
// RV32IM decoder (combinational, ID stage) plus EX ALU, branch comparator and
// the one-cycle registered result/redirect stage.
module rv32_decode_exec_unit
  import rv32_decode_exec_unit_pkg::*;
(
  input logic                   clk,
  input logic                   reset,
  rv32_decode_exec_unit_if.slave bus
);

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  assign instr  = bus.instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign bus.rd  = instr[11:7];
  assign bus.rs1 = instr[19:15];
  assign bus.rs2 = instr[24:20];

  // Decoder: everything defaults to inactive so an unknown opcode only raises
  // decoder_illegal.
  always_comb begin
    bus.imm                = 32'h0;
    bus.alu_op             = ALU_ADD;
    bus.div_op             = 3'b000;
    bus.reg_write          = 1'b0;
    bus.alu_src            = 1'b0;
    bus.is_branch          = 1'b0;
    bus.jal_jump           = 1'b0;
    bus.jalr_jump          = 1'b0;
    bus.is_load            = 1'b0;
    bus.is_store           = 1'b0;
    bus.div_start          = 1'b0;
    bus.is_div_instruction = 1'b0;
    bus.is_lui             = 1'b0;
    bus.is_auipc           = 1'b0;
    bus.cpu_halt           = 1'b0;
    bus.decoder_illegal    = 1'b0;
    bus.b_type             = 3'b000;
    bus.load_type          = 3'b000;
    bus.store_type         = 3'b000;
    bus.csr_func           = 3'b000;
    case (opcode)
      OPC_OP: begin
        bus.reg_write = 1'b1;
        if (funct7 == 7'h01) begin
          if (funct3[2]) begin
            bus.is_div_instruction = 1'b1;
            bus.div_start          = 1'b1;
            bus.div_op             = funct3;
          end else begin
            case (funct3[1:0])
              2'b00:   bus.alu_op = ALU_MUL;
              2'b01:   bus.alu_op = ALU_MULH;
              2'b10:   bus.alu_op = ALU_MULHSU;
              default: bus.alu_op = ALU_MULHU;
            endcase
          end
        end else begin
          bus.alu_op = base_alu_op(funct3, instr[30], 1'b1);
        end
      end
      OPC_OP_IMM: begin
        bus.reg_write = 1'b1;
        bus.alu_src   = 1'b1;
        bus.imm       = {{20{instr[31]}}, instr[31:20]};
        bus.alu_op    = base_alu_op(funct3, instr[30], 1'b0);
      end
      OPC_LOAD: begin
        bus.reg_write = 1'b1;
        bus.alu_src   = 1'b1;
        bus.is_load   = 1'b1;
        bus.load_type = funct3;
        bus.imm       = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        bus.alu_src    = 1'b1;
        bus.is_store   = 1'b1;
        bus.store_type = funct3;
        bus.imm        = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        bus.is_branch = 1'b1;
        bus.b_type    = funct3;
        bus.imm       = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_JAL: begin
        bus.reg_write = 1'b1;
        bus.jal_jump  = 1'b1;
        bus.imm       = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        bus.reg_write = 1'b1;
        bus.jalr_jump = 1'b1;
        bus.alu_src   = 1'b1;
        bus.imm       = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_LUI: begin
        bus.reg_write = 1'b1;
        bus.is_lui    = 1'b1;
        bus.imm       = {instr[31:12], 12'h0};
      end
      OPC_AUIPC: begin
        bus.reg_write = 1'b1;
        bus.is_auipc  = 1'b1;
        bus.imm       = {instr[31:12], 12'h0};
      end
      OPC_SYSTEM: begin
        bus.imm = {{20{instr[31]}}, instr[31:20]};
        if (funct3 == 3'b000) bus.cpu_halt = 1'b1;
        else                  bus.csr_func = funct3;
      end
      default: bus.decoder_illegal = 1'b1;
    endcase
  end

  ex_ctl_t     ctl;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic [31:0] pc_plus_imm;
  logic        taken;
  logic [31:0] next_result;
  logic [31:0] next_target;
  logic        next_flush;

  assign ctl         = bus.ctl_ex;
  assign alu_b       = ctl.alu_src ? bus.imm_ex : bus.rs2_val;
  assign pc_plus_imm = bus.pc + bus.imm_ex;

  rv32_alu_core u_alu (
    .a  (bus.rs1_val),
    .b  (alu_b),
    .op (ctl.alu_op),
    .y  (alu_y)
  );

  always_comb begin
    taken = 1'b0;
    case (ctl.b_type)
      BR_EQ:   taken = (bus.rs1_val == bus.rs2_val);
      BR_NE:   taken = (bus.rs1_val != bus.rs2_val);
      BR_LT:   taken = ($signed(bus.rs1_val) < $signed(bus.rs2_val));
      BR_GE:   taken = ($signed(bus.rs1_val) >= $signed(bus.rs2_val));
      BR_LTU:  taken = (bus.rs1_val < bus.rs2_val);
      BR_GEU:  taken = (bus.rs1_val >= bus.rs2_val);
      default: taken = 1'b0;
    endcase
  end

  // Jumps write the link address; only JALR takes its target from rs1.
  always_comb begin
    if (ctl.jal_jump || ctl.jalr_jump) next_result = bus.pc + 32'd4;
    else if (ctl.is_lui)               next_result = bus.imm_ex;
    else if (ctl.is_auipc)             next_result = pc_plus_imm;
    else                               next_result = alu_y;
    next_target = ctl.jalr_jump ? ((bus.rs1_val + bus.imm_ex) & ~32'h1) : pc_plus_imm;
    next_flush  = ctl.jal_jump | ctl.jalr_jump | (ctl.is_branch & taken);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.result_q    <= 32'h0;
      bus.pc_target_q <= 32'h0;
      bus.flush_q     <= 1'b0;
    end else if (!bus.stall) begin
      bus.result_q    <= next_result;
      bus.pc_target_q <= next_target;
      bus.flush_q     <= next_flush;
    end
  end

endmodule

// File: tb/tb_rv32_decode_exec_unit.sv
// Bench for rv32_decode_exec_unit: directed plan cases plus randomized ALU and
// branch instructions scored against an instruction-level reference model.
module tb_rv32_decode_exec_unit;
  import rv32_decode_exec_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  rv32_decode_exec_unit_if bus();

  rv32_decode_exec_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  string r_ops[14] = '{"add", "sub", "sll", "slt", "sltu", "xor", "srl", "sra",
                       "or", "and", "mul", "mulh", "mulhsu", "mulhu"};
  string i_ops[9]  = '{"addi", "slti", "sltiu", "xori", "ori", "andi",
                       "slli", "srli", "srai"};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives ID and EX with the same instruction; the EX control copy is taken
  // from the decode outputs, playing the role of the ID/EX register.
  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc_v,
                               input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.instr   = ins;
    bus.pc      = pc_v;
    bus.rs1_val = a;
    bus.rs2_val = b;
    #1;
    bus.imm_ex            = bus.imm;
    bus.ctl_ex.alu_op     = bus.alu_op;
    bus.ctl_ex.alu_src    = bus.alu_src;
    bus.ctl_ex.b_type     = bus.b_type;
    bus.ctl_ex.is_branch  = bus.is_branch;
    bus.ctl_ex.jal_jump   = bus.jal_jump;
    bus.ctl_ex.jalr_jump  = bus.jalr_jump;
    bus.ctl_ex.is_lui     = bus.is_lui;
    bus.ctl_ex.is_auipc   = bus.is_auipc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_alu(input string m, input logic [31:0] a, input logic [31:0] b);
    longint      ps;
    logic [63:0] pu;
    logic [31:0] r;
    r = 32'h0;
    case (m)
      "add", "addi":  r = a + b;
      "sub":          r = a - b;
      "sll", "slli":  r = a << b[4:0];
      "slt", "slti":  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      "sltu", "sltiu": r = (a < b) ? 32'd1 : 32'd0;
      "xor", "xori":  r = a ^ b;
      "srl", "srli":  r = a >> b[4:0];
      "sra", "srai":  r = $signed(a) >>> b[4:0];
      "or", "ori":    r = a | b;
      "and", "andi":  r = a & b;
      "mul":          r = a * b;
      "mulh": begin
        ps = longint'($signed(a)) * longint'($signed(b));
        r  = ps[63:32];
      end
      "mulhsu": begin
        ps = longint'($signed(a)) * longint'({32'h0, b});
        r  = ps[63:32];
      end
      "mulhu": begin
        pu = {32'h0, a} * {32'h0, b};
        r  = pu[63:32];
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic [9:0] r_code(input string m);
    logic [9:0] c;
    case (m)
      "add":    c = {7'h00, 3'd0};
      "sub":    c = {7'h20, 3'd0};
      "sll":    c = {7'h00, 3'd1};
      "slt":    c = {7'h00, 3'd2};
      "sltu":   c = {7'h00, 3'd3};
      "xor":    c = {7'h00, 3'd4};
      "srl":    c = {7'h00, 3'd5};
      "sra":    c = {7'h20, 3'd5};
      "or":     c = {7'h00, 3'd6};
      "and":    c = {7'h00, 3'd7};
      "mul":    c = {7'h01, 3'd0};
      "mulh":   c = {7'h01, 3'd1};
      "mulhsu": c = {7'h01, 3'd2};
      default:  c = {7'h01, 3'd3};
    endcase
    return c;
  endfunction

  function automatic logic [2:0] i_funct3(input string m);
    case (m)
      "addi":  return 3'd0;
      "slti":  return 3'd2;
      "sltiu": return 3'd3;
      "xori":  return 3'd4;
      "ori":   return 3'd6;
      "andi":  return 3'd7;
      "slli":  return 3'd1;
      default: return 3'd5;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    logic [31:0] a, b, pc_v, ins, exp_b;
    logic [11:0] imm12;
    logic [12:0] off;
    logic [4:0]  rd_v, rs1_v, rs2_v;
    logic [9:0]  code;
    logic [2:0]  f3;
    string       m;

    reset       = 1'b0;
    bus.stall   = 1'b0;
    bus.instr   = 32'h0;
    bus.pc      = 32'h0;
    bus.rs1_val = 32'h0;
    bus.rs2_val = 32'h0;
    bus.imm_ex  = 32'h0;
    bus.ctl_ex  = '0;
    #12;
    checkOutput("reset_result", bus.result_q, 32'h0);
    checkOutput("reset_target", bus.pc_target_q, 32'h0);
    checkOutput("reset_flush", {31'h0, bus.flush_q}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(32'h00500093, 32'h0, 32'h0, 32'h0);
    checkOutput("addi_rd", {27'h0, bus.rd}, 32'd1);
    checkOutput("addi_imm", bus.imm, 32'd5);
    checkOutput("addi_alu_src", {31'h0, bus.alu_src}, 32'd1);
    checkOutput("addi_reg_write", {31'h0, bus.reg_write}, 32'd1);
    checkOutput("addi_result", bus.result_q, 32'd5);

    applyStimulus(32'h402081B3, 32'h0, 32'd3, 32'd5);
    checkOutput("sub_result", bus.result_q, 32'hFFFFFFFE);

    @(negedge clk);
    bus.stall = 1'b1;
    applyStimulus(32'h00500093, 32'h0, 32'h0, 32'h0);
    checkOutput("stall_hold_result", bus.result_q, 32'hFFFFFFFE);
    bus.stall = 1'b0;

    applyStimulus(32'h00208463, 32'h100, 32'd7, 32'd7);
    checkOutput("beq_taken_flush", {31'h0, bus.flush_q}, 32'd1);
    checkOutput("beq_taken_target", bus.pc_target_q, 32'h108);
    applyStimulus(32'h00208463, 32'h100, 32'd7, 32'd8);
    checkOutput("beq_not_taken_flush", {31'h0, bus.flush_q}, 32'd0);

    applyStimulus(32'h008000EF, 32'h20, 32'h0, 32'h0);
    checkOutput("jal_result", bus.result_q, 32'h24);
    checkOutput("jal_target", bus.pc_target_q, 32'h28);
    checkOutput("jal_flush", {31'h0, bus.flush_q}, 32'd1);
    applyStimulus(32'h00500093, 32'h24, 32'h0, 32'h0);
    checkOutput("flush_one_cycle", {31'h0, bus.flush_q}, 32'd0);

    applyStimulus(32'h005280E7, 32'h40, 32'h100, 32'h0);
    checkOutput("jalr_target", bus.pc_target_q, 32'h104);
    checkOutput("jalr_result", bus.result_q, 32'h44);
    checkOutput("jalr_flush", {31'h0, bus.flush_q}, 32'd1);

    applyStimulus(32'h123450B7, 32'h0, 32'h0, 32'h0);
    checkOutput("lui_imm", bus.imm, 32'h12345000);
    checkOutput("lui_result", bus.result_q, 32'h12345000);

    applyStimulus(32'h12345097, 32'h1000, 32'h0, 32'h0);
    checkOutput("auipc_result", bus.result_q, 32'h12346000);

    applyStimulus(32'hFFC0A183, 32'h0, 32'h1000, 32'h0);
    checkOutput("lw_imm", bus.imm, 32'hFFFFFFFC);
    checkOutput("lw_is_load", {31'h0, bus.is_load}, 32'd1);
    checkOutput("lw_load_type", {29'h0, bus.load_type}, 32'd2);
    checkOutput("lw_addr", bus.result_q, 32'h00000FFC);

    applyStimulus(32'h0020A423, 32'h0, 32'h0, 32'h0);
    checkOutput("sw_imm", bus.imm, 32'd8);
    checkOutput("sw_is_store", {31'h0, bus.is_store}, 32'd1);
    checkOutput("sw_store_type", {29'h0, bus.store_type}, 32'd2);
    checkOutput("sw_reg_write", {31'h0, bus.reg_write}, 32'd0);

    applyStimulus(32'h0220C1B3, 32'h0, 32'd9, 32'd2);
    checkOutput("div_flag", {31'h0, bus.is_div_instruction}, 32'd1);
    checkOutput("div_start", {31'h0, bus.div_start}, 32'd1);
    checkOutput("div_op", {29'h0, bus.div_op}, 32'd4);

    applyStimulus(32'h00000073, 32'h0, 32'h0, 32'h0);
    checkOutput("ecall_halt", {31'h0, bus.cpu_halt}, 32'd1);
    applyStimulus(32'h00001073, 32'h0, 32'h0, 32'h0);
    checkOutput("csr_func", {29'h0, bus.csr_func}, 32'd1);
    checkOutput("csr_no_halt", {31'h0, bus.cpu_halt}, 32'd0);

    applyStimulus(32'h00000000, 32'h0, 32'h0, 32'h0);
    checkOutput("illegal_flag", {31'h0, bus.decoder_illegal}, 32'd1);
    checkOutput("illegal_reg_write", {31'h0, bus.reg_write}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      rd_v  = 5'($urandom_range(1, 31));
      rs1_v = 5'($urandom);
      rs2_v = 5'($urandom);
      a     = $urandom;
      b     = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        m    = r_ops[$urandom_range(0, 13)];
        code = r_code(m);
        ins  = {code[9:3], rs2_v, rs1_v, code[2:0], rd_v, 7'h33};
        exp_b = b;
      end else begin
        m     = i_ops[$urandom_range(0, 8)];
        imm12 = 12'($urandom);
        if (m == "slli" || m == "srli") imm12 = {7'h00, imm12[4:0]};
        if (m == "srai")                imm12 = {7'h20, imm12[4:0]};
        ins   = {imm12, rs1_v, i_funct3(m), rd_v, 7'h13};
        exp_b = {{20{imm12[11]}}, imm12};
      end
      applyStimulus(ins, 32'h0, a, b);
      checkOutput({"rand_", m}, bus.result_q, ref_alu(m, a, exp_b));
      checkOutput({"rand_rd_", m}, {27'h0, bus.rd}, {27'h0, rd_v});
    end

    for (int i = 0; i < 24; i++) begin
      f3   = 3'($urandom);
      a    = $urandom;
      b    = ($urandom_range(0, 2) == 0) ? a : $urandom;
      off  = 13'($urandom) & 13'h1FFE;
      pc_v = $urandom & 32'hFFFFFFFC;
      ins  = {off[12], off[10:5], 5'd2, 5'd1, f3, off[4:1], off[11], 7'h63};
      applyStimulus(ins, pc_v, a, b);
      checkOutput("rand_br_flush", {31'h0, bus.flush_q}, {31'h0, ref_taken(f3, a, b)});
      checkOutput("rand_br_target", bus.pc_target_q, pc_v + {{19{off[12]}}, off});
    end

    applyStimulus(32'h008000EF, 32'h20, 32'h0, 32'h0);
    checkOutput("pre_reset_flush", {31'h0, bus.flush_q}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_flush", {31'h0, bus.flush_q}, 32'd0);
    checkOutput("async_reset_result", bus.result_q, 32'h0);
    checkOutput("async_reset_target", bus.pc_target_q, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("edge_in_reset_flush", {31'h0, bus.flush_q}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(32'h00500093, 32'h0, 32'h0, 32'h0);
    checkOutput("post_reset_result", bus.result_q, 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/rv32_decode_exec_unit.md
# rv32_decode_exec_unit

Combined RV32IM instruction decoder, integer ALU and branch comparator for the five-stage CPU pipeline. Decode outputs are combinational and feed the ID/EX register. The execute result, redirect target and flush are registered once, so a taken jump or branch redirects fetch exactly one cycle after EX. Divide is not executed here; it is only decoded for the external divider.

## Interface
- No parameters; XLEN fixed at 32.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low.
- `stall` in 1: holds all registered outputs.
- `instr` in 32: instruction word in ID.
- `pc` in 32: PC of the instruction in EX.
- `rs1_val`, `rs2_val` in 32: forwarded EX operands.
- `imm_ex` in 32: immediate of the instruction in EX.
- `ctl_ex` in bundle: EX copy of `alu_op`, `alu_src`, `b_type`, `is_branch`, `jal_jump`, `jalr_jump`, `is_lui`, `is_auipc`.
- Decode outputs (combinational):
  - `rd`, `rs1`, `rs2` out 5: register fields.
  - `imm` out 32: sign-extended immediate.
  - `alu_op` out 5.
  - `div_op` out 3.
  - Control out 1 each: `reg_write`, `alu_src`, `is_branch`, `jal_jump`, `jalr_jump`, `is_load`, `is_store`, `div_start`, `is_div_instruction`, `is_lui`, `is_auipc`, `cpu_halt`, `decoder_illegal`.
  - `b_type`, `load_type`, `store_type`, `csr_func` out 3.
- `result_q` out 32: registered EX result.
- `pc_target_q` out 32: registered redirect target.
- `flush_q` out 1: registered redirect request.

## Operation
- Immediate formats:
  - I: `instr[31:20]`, sign-extended.
  - S: `{31:25, 11:7}`.
  - B: `{31, 7, 30:25, 11:8, 0}`.
  - U: `{31:12, 12'b0}`.
  - J: `{31, 19:12, 20, 30:21, 0}`.
- Opcode decode:
  - OP (0x33): `reg_write` = 1, `alu_src` = 0. When funct7 = 0x01 and funct3 is 4–7, this is DIV/DIVU/REM/REMU: set `is_div_instruction` and `div_start`, and `div_op` = funct3.
  - OP-IMM (0x13): `alu_src` = 1.
  - LOAD (0x03): `is_load` = 1, `load_type` = funct3, `alu_op` = ADD.
  - STORE (0x23): `is_store` = 1, `store_type` = funct3, `reg_write` = 0.
  - BRANCH (0x63): `is_branch` = 1, `b_type` = funct3.
  - JAL (0x6F) and JALR (0x67): `reg_write` = 1.
  - LUI (0x37) and AUIPC (0x17).
  - SYSTEM (0x73): funct3 = 0 sets `cpu_halt` (ECALL/EBREAK); any other funct3 drives `csr_func` = funct3.
  - Any other opcode sets `decoder_illegal` and forces all write/control outputs to 0.
- `alu_op` codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU.
  - Undefined codes produce 0.
- ALU rules:
  - Shifts use only `b[4:0]`.
  - SUB and SRA are selected when `instr[30]` = 1.
- Branch conditions by `b_type`:
  - 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - 010 and 011 never take.
- EX result priority:
  1. Jump: `pc+4`.
  2. LUI: imm.
  3. AUIPC: `pc+imm`.
  4. Otherwise the ALU result.
- Redirect target:
  - JALR: `(rs1+imm) & ~1`.
  - Otherwise `pc+imm`.
- `flush` condition: `jal_jump | jalr_jump | (is_branch & taken)`.

## Timing
- Decode outputs are purely combinational from `instr`.
- `result_q`, `pc_target_q` and `flush_q` update on the rising edge after their EX inputs are valid (latency 1).
- While `stall` = 1, all registered outputs hold their values.
- When `reset` goes low, all registered outputs clear to 0 immediately. They resume updating on the first clock edge after `reset` is released.
- An edge that occurs while `reset` is low never produces a flush.
- `flush_q` is high for exactly one cycle per redirecting instruction unless the bench presents the same instruction again.

## Structure
- Shared package holds:
  - Opcode constants.
  - The `alu_op` enum.
  - Branch funct3 codes.
  - Load/store width codes.
- Natural sub-modules:
  - `rv32_alu_core`: combinational ALU including the multiply ops.
  - The decoder, written as one combinational `always` block.
  - The registered EX output stage.

## Test plan
- `instr` = 0x00500093 (ADDI x1,x0,5), with EX presenting it and `rs1_val` = 0 → `rd` = 1, `imm` = 5, `alu_src` = 1, `reg_write` = 1. Next cycle `result_q` = 5.
- `instr` = 0x402081B3 (SUB x3,x1,x2) with `rs1_val` = 3, `rs2_val` = 5 → `result_q` = 0xFFFFFFFE.
- `instr` = 0x00208463 (BEQ x1,x2,+8) with `pc` = 0x100:
  - `rs1_val` = `rs2_val` = 7 → `flush_q` = 1 and `pc_target_q` = 0x108 after one edge.
  - With `rs2_val` = 8 → `flush_q` = 0.
- `instr` = 0x008000EF (JAL x1,+8) with `pc` = 0x20 → `result_q` = 0x24, `pc_target_q` = 0x28, `flush_q` = 1.
- `instr` = 0x123450B7 (LUI x1) → `imm` = 0x12345000, `result_q` = 0x12345000.
- `instr` = 0x00000000 → `decoder_illegal` = 1, `reg_write` = 0.
- Assert `reset` low mid-cycle while `flush_q` = 1 → `flush_q`, `result_q` and `pc_target_q` are 0 before the next edge.
